multi_timer: RTL

Parametrised multi-channel countdown timer: N_CH independent hours/minutes/seconds/centiseconds counters sharing one centisecond prescaler. Each channel supports one-shot or auto-reload mode.

- The same pushbutton pulses (inc, dec, state, start) edit, start, pause and clear whichever channel `ch` selects.
- The block is active on the front panel when `sel` equals the timer selection code.
- Its displayed fields feed the existing seven-segment/UART display path.

---
 rtl/timer_pkg.sv | 37 +++
 rtl/timer_channel.sv | 176 +++++++++++++++++
 rtl/multi_timer.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } tstate_t;

  typedef enum logic [1:0] {
    SEC = 2'd0,
    MIN = 2'd1,
    HR  = 2'd2
  } field_t;

  localparam logic [1:0] SEL_TIMER = 2'd2;
  localparam logic [6:0] CS_MAX    = 7'd99;
  localparam logic [5:0] SM_MAX    = 6'd59;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  function automatic field_t next_field(input field_t f);
    case (f)
      SEC:     return MIN;
      MIN:     return HR;
      default: return SEC;
    endcase
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: preset/count registers, field editing, FSM and borrow chain.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned HoursMax = 23
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       strobe_i,
  input  logic       start_i,
  input  logic       step_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       mode_i,
  output logic [5:0] hours_o,
  output logic [5:0] minutes_o,
  output logic [5:0] seconds_o,
  output logic [6:0] cs_o,
  output tstate_t    state_o,
  output logic       done_o
);

  localparam logic [5:0] HrMax = 6'(HoursMax);

  logic [5:0] pre_h_q, pre_m_q, pre_s_q;
  logic [5:0] cnt_h_q, cnt_m_q, cnt_s_q;
  logic [6:0] cnt_cs_q;
  field_t     field_q;
  tstate_t    state_q;
  logic       reload_q;
  logic       done_q;

  logic [5:0] edit_cur, edit_max, edit_val;
  logic [5:0] dec_h, dec_m, dec_s;
  logic [6:0] dec_cs;
  logic       dec_zero;
  logic       preset_zero;

  assign preset_zero = (pre_h_q == 6'd0) && (pre_m_q == 6'd0) && (pre_s_q == 6'd0);

  // New value of the field under edit; only consumed when inc or dec is active.
  always_comb begin
    edit_cur = pre_s_q;
    edit_max = SM_MAX;
    case (field_q)
      MIN: edit_cur = pre_m_q;
      HR: begin
        edit_cur = pre_h_q;
        edit_max = HrMax;
      end
      default: edit_cur = pre_s_q;
    endcase
    edit_val = inc_i ? wrap_inc(edit_cur, edit_max) : wrap_dec(edit_cur, edit_max);
  end

  // One-centisecond decrement with borrows cs -> s -> m -> h.
  always_comb begin
    dec_h  = cnt_h_q;
    dec_m  = cnt_m_q;
    dec_s  = cnt_s_q;
    dec_cs = cnt_cs_q - 7'd1;
    if (cnt_cs_q == 7'd0) begin
      dec_cs = CS_MAX;
      if (cnt_s_q == 6'd0) begin
        dec_s = SM_MAX;
        if (cnt_m_q == 6'd0) begin
          dec_m = SM_MAX;
          dec_h = cnt_h_q - 6'd1;
        end else begin
          dec_m = cnt_m_q - 6'd1;
        end
      end else begin
        dec_s = cnt_s_q - 6'd1;
      end
    end
    dec_zero = (dec_h == 6'd0) && (dec_m == 6'd0) && (dec_s == 6'd0) && (dec_cs == 7'd0);
  end

  // Channel FSM; action inputs are one-hot so at most one branch fires per cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pre_h_q  <= '0;
      pre_m_q  <= '0;
      pre_s_q  <= '0;
      cnt_h_q  <= '0;
      cnt_m_q  <= '0;
      cnt_s_q  <= '0;
      cnt_cs_q <= '0;
      field_q  <= SEC;
      state_q  <= IDLE;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            if (!preset_zero) begin
              state_q  <= RUN;
              reload_q <= mode_i;
            end
          end else if (step_i) begin
            field_q <= next_field(field_q);
          end else if (inc_i || dec_i) begin
            // Count mirrors preset while idle, so both take the edit.
            case (field_q)
              MIN: begin
                pre_m_q <= edit_val;
                cnt_m_q <= edit_val;
              end
              HR: begin
                pre_h_q <= edit_val;
                cnt_h_q <= edit_val;
              end
              default: begin
                pre_s_q <= edit_val;
                cnt_s_q <= edit_val;
              end
            endcase
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= PAUSE;
          end else if (strobe_i) begin
            if (dec_zero) begin
              done_q <= 1'b1;
              if (reload_q) begin
                cnt_h_q  <= pre_h_q;
                cnt_m_q  <= pre_m_q;
                cnt_s_q  <= pre_s_q;
                cnt_cs_q <= '0;
              end else begin
                state_q  <= EXPIRED;
                cnt_h_q  <= '0;
                cnt_m_q  <= '0;
                cnt_s_q  <= '0;
                cnt_cs_q <= '0;
              end
            end else begin
              cnt_h_q  <= dec_h;
              cnt_m_q  <= dec_m;
              cnt_s_q  <= dec_s;
              cnt_cs_q <= dec_cs;
            end
          end
        end
        PAUSE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
          end
        end
        EXPIRED: begin
          if (step_i) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            cnt_h_q  <= pre_h_q;
            cnt_m_q  <= pre_m_q;
            cnt_s_q  <= pre_s_q;
            cnt_cs_q <= '0;
          end
        end
      endcase
    end
  end

  assign hours_o   = cnt_h_q;
  assign minutes_o = cnt_m_q;
  assign seconds_o = cnt_s_q;
  assign cs_o      = cnt_cs_q;
  assign state_o   = state_q;
  assign done_o    = done_q;

endmodule

// File: rtl/multi_timer.sv
// N_CH countdown channels behind one shared centisecond prescaler and one set of buttons.
module multi_timer
  import timer_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CLKS_PER_CS = 1,
  parameter int unsigned HOURS_MAX   = 23
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [1:0]                            sel,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch,
  input  logic                                  mode,
  input  logic                                  inc,
  input  logic                                  dec,
  input  logic                                  state,
  input  logic                                  start,
  output logic [5:0]                            hours,
  output logic [5:0]                            minutes,
  output logic [5:0]                            seconds,
  output logic [6:0]                            milliseconds,
  output logic [1:0]                            ch_state,
  output logic [N_CH-1:0]                       done
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PS_W = (CLKS_PER_CS > 1) ? $clog2(CLKS_PER_CS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_CS - 1);

  logic [PS_W-1:0] ps_q;
  logic            strobe;

  // Button order: [3] start, [2] state, [1] inc, [0] dec.
  logic [3:0] btn, btn_prev_q, btn_edge, act;

  logic [5:0] ch_h  [N_CH];
  logic [5:0] ch_m  [N_CH];
  logic [5:0] ch_s  [N_CH];
  logic [6:0] ch_cs [N_CH];
  tstate_t    ch_st [N_CH];

  assign strobe = (ps_q == PS_LAST);

  // Free-running prescaler, independent of panel activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= strobe ? '0 : ps_q + 1'b1;
    end
  end

  assign btn      = {start, state, inc, dec};
  assign btn_edge = btn & ~btn_prev_q;

  // Previous button levels; updated even when the panel is not on the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_q <= '0;
    end else begin
      btn_prev_q <= btn;
    end
  end

  // Keep only the highest-priority edge: start > state > inc > dec.
  always_comb begin
    act = 4'b0000;
    if (sel == SEL_TIMER) begin
      if (btn_edge[3])      act = 4'b1000;
      else if (btn_edge[2]) act = 4'b0100;
      else if (btn_edge[1]) act = 4'b0010;
      else if (btn_edge[0]) act = 4'b0001;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = (ch == CH_W'(i));

    timer_channel #(
      .HoursMax(HOURS_MAX)
    ) u_ch (
      .clk_i    (clk),
      .reset_i  (reset),
      .strobe_i (strobe),
      .start_i  (hit & act[3]),
      .step_i   (hit & act[2]),
      .inc_i    (hit & act[1]),
      .dec_i    (hit & act[0]),
      .mode_i   (mode),
      .hours_o  (ch_h[i]),
      .minutes_o(ch_m[i]),
      .seconds_o(ch_s[i]),
      .cs_o     (ch_cs[i]),
      .state_o  (ch_st[i]),
      .done_o   (done[i])
    );
  end

  // Display mux of the addressed channel; unpopulated codes read as zero/IDLE.
  always_comb begin
    hours        = '0;
    minutes      = '0;
    seconds      = '0;
    milliseconds = '0;
    ch_state     = IDLE;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch == CH_W'(i)) begin
        hours        = ch_h[i];
        minutes      = ch_m[i];
        seconds      = ch_s[i];
        milliseconds = ch_cs[i];
        ch_state     = ch_st[i];
      end
    end
  end

endmodule
